// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared constants and state encoding for the ADC bit-serial
// capture front end.
//   cap_state_e      : capture FSM state (IDLE, ARMED, CAPTURE, DONE)
//   *_DEF constants  : default parameter values for the capture blocks
package adc_cap_pkg;

  localparam int SAMPLE_W_DEF    = 8;
  localparam int DEPTH_DEF       = 16384;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_cap_word_serializer.sv
// adc_word_serializer: turns accepted ADC samples into an MSB-first bit
// stream with a FIFO write enable, counts written bits and flags dropped
// samples.
//   wrclk, rst    : write clock, async active-high reset
//   en            : capture window (FSM in CAPTURE)
//   clr           : clears bit_count and overrun (arm accepted)
//   sample*       : parallel sample and its one-cycle qualifier
//   din, wren     : registered serial bit and write enable
//   overrun       : sticky, a sample arrived while a word was in flight
//   bit_count     : bits written in this capture
//   last_wr       : the bit now on din/wren is the final one of the capture
module adc_word_serializer
  import adc_cap_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                     wrclk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [SAMPLE_W-1:0]      sample,
  input  logic                     sample_valid,
  output logic                     din,
  output logic                     wren,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   bit_count,
  output logic                     last_wr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(SAMPLE_W + 1);

  logic [SAMPLE_W-1:0] shreg;
  logic [RW-1:0]       rem;     // bits still to emit after the one on din
  logic                sh_busy;
  logic                take;

  assign sh_busy = (rem != '0);
  // bit_count counts completed writes, so the final write is the one on
  // the wires while the count sits at DEPTH-1.
  assign last_wr = wren && (bit_count == CW'(DEPTH - 1));
  // No new word may start on the edge that closes the capture.
  assign take    = en && sample_valid && !sh_busy && !last_wr;

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      rem       <= '0;
      din       <= 1'b0;
      wren      <= 1'b0;
      overrun   <= 1'b0;
      bit_count <= '0;
    end else begin
      if (take) begin
        din   <= sample[SAMPLE_W-1];
        wren  <= 1'b1;
        shreg <= sample << 1;
        rem   <= RW'(SAMPLE_W - 1);
      end else if (sh_busy) begin
        din   <= shreg[SAMPLE_W-1];
        wren  <= 1'b1;
        shreg <= shreg << 1;
        rem   <= rem - RW'(1);
      end else begin
        din   <= 1'b0;
        wren  <= 1'b0;
      end

      if (clr)       bit_count <= '0;
      else if (wren) bit_count <= bit_count + CW'(1);

      // rem != 0 also covers the edge that emits the word's last bit.
      if (clr)                            overrun <= 1'b0;
      else if (en && sample_valid && sh_busy) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_bit_serial_capture.sv
// adc_bit_serial_capture: arms on request, waits for a trigger, then
// serializes DEPTH bits of ADC samples MSB-first into the capture FIFO.
// Optional feature macro: TRIG_THRESHOLD_EN (adds a rising threshold
// crossing on the sample stream as a trigger source while ARMED).
//   wrclk, rst          : FIFO write clock, async active-high reset
//   arm                 : one-cycle pulse, starts a capture from IDLE/DONE
//   trig                : asynchronous trigger level, rising edge is the event
//   sample/sample_valid : parallel ADC sample and qualifier
//   thr                 : threshold level (threshold trigger only)
//   din, wren           : serial bit and write enable to the FIFO
//   armed, busy, done   : state flags (ARMED, CAPTURE, DONE)
//   overrun             : sticky dropped-sample flag
//   bit_count           : bits written in the current capture
module adc_bit_serial_capture
  import adc_cap_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                   wrclk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   trig,
  input  logic [SAMPLE_W-1:0]    sample,
  input  logic                   sample_valid,
  input  logic [SAMPLE_W-1:0]    thr,
  output logic                   din,
  output logic                   wren,
  output logic                   armed,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] bit_count
);

  logic [SYNC_STAGES-1:0] trig_sync;
  logic                   trig_d;
  logic                   trig_rise;
  logic                   trig_evt;
  logic                   last_wr;
  logic                   arm_ok;
  cap_state_e             state, state_nx;

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      trig_sync <= '0;
      trig_d    <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig};
      trig_d    <= trig_sync[SYNC_STAGES-1];
    end
  end

  assign trig_rise = trig_sync[SYNC_STAGES-1] & ~trig_d;

`ifdef TRIG_THRESHOLD_EN
  // Resets to all ones so the first sample can never look like a crossing.
  logic [SAMPLE_W-1:0] prev_sample;
  logic                thr_cross;

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst)               prev_sample <= '1;
    else if (sample_valid) prev_sample <= sample;
  end

  assign thr_cross = sample_valid && (prev_sample < thr) && (sample >= thr);
  assign trig_evt  = trig_rise | thr_cross;
`else
  logic unused_thr;
  assign unused_thr = ^thr;
  assign trig_evt   = trig_rise;
`endif

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      armed <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= (state_nx == ST_ARMED);
      busy  <= (state_nx == ST_CAPTURE);
      done  <= (state_nx == ST_DONE);
    end
  end

  // A trigger seen in IDLE is simply lost: it has to recur while ARMED.
  always_comb begin
    state_nx = state;
    arm_ok   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (arm) begin
        state_nx = ST_ARMED;
        arm_ok   = 1'b1;
      end
      ST_ARMED:   if (trig_evt) state_nx = ST_CAPTURE;
      ST_CAPTURE: if (last_wr)  state_nx = ST_DONE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  adc_word_serializer #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH)
  ) u_ser (
    .wrclk        (wrclk),
    .rst          (rst),
    .en           (state == ST_CAPTURE),
    .clr          (arm_ok),
    .sample       (sample),
    .sample_valid (sample_valid),
    .din          (din),
    .wren         (wren),
    .overrun      (overrun),
    .bit_count    (bit_count),
    .last_wr      (last_wr)
  );

endmodule

// File: tb/tb_adc_bit_serial_capture.sv
// tb_adc_bit_serial_capture: randomized self-checking bench. Reference is a
// queue of the words that should appear on the serial stream; a monitor
// reassembles din into words on every wren cycle.
module tb_adc_bit_serial_capture;

  localparam int SW     = 8;
  localparam int DEPTH  = 16384;
  localparam int CW     = 15;
  localparam int NWORDS = DEPTH / SW;

  logic          wrclk = 1'b0;
  logic          rst, arm, trig, sample_valid;
  logic [SW-1:0] sample, thr;
  logic          din, wren, armed, busy, done, overrun;
  logic [CW-1:0] bit_count;

  int n_chk = 0;
  int n_err = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] obs_q[$];
  int            obs_base  = 0;
  int            wren_base = 0;
  int            wren_total = 0;
  int            mon_bits = 0;
  logic [SW-1:0] mon_word = '0;

  always #5 wrclk = ~wrclk;

  adc_bit_serial_capture dut (
    .wrclk        (wrclk),
    .rst          (rst),
    .arm          (arm),
    .trig         (trig),
    .sample       (sample),
    .sample_valid (sample_valid),
    .thr          (thr),
    .din          (din),
    .wren         (wren),
    .armed        (armed),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .bit_count    (bit_count)
  );

  // Monitor: one FIFO write per wren cycle, sampled mid-cycle.
  always @(negedge wrclk) begin
    if (rst) begin
      mon_bits <= 0;
    end else if (wren) begin
      wren_total <= wren_total + 1;
      if (mon_bits == SW - 1) begin
        obs_q.push_back({mon_word[SW-2:0], din});
        mon_bits <= 0;
      end else begin
        mon_word <= {mon_word[SW-2:0], din};
        mon_bits <= mon_bits + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge wrclk);
    #1;
  endtask

  task automatic do_arm();
    arm       = 1'b1;
    wren_base = wren_total;
    obs_base  = obs_q.size();
    exp_q.delete();
    step();
    arm = 1'b0;
  endtask

  // Raise trig mid-cycle while streaming samples; none of them may be kept.
  task automatic fire_trig();
    int n = 0;
    sample       = 8'h3C;
    sample_valid = 1'b1;
    trig         = 1'b1;
    while (!busy && n < 20) begin
      step();
      n++;
    end
    sample_valid = 1'b0;
    chk("trig_latency_3to4", 32'(n >= 3 && n <= 4), 1);
    step();
    chk("coincident_not_serialized", 32'(wren), 0);
    trig = 1'b0;
  endtask

  // Send samples at least SW cycles apart until stop_bits writes are seen.
  task automatic feed(input int stop_bits, input logic [SW-1:0] first,
                      input bit mid_arm, input int ovr_at);
    int gap = 0, words = 0, cyc = 0;
    bit inject = 0, arm_done = 0, arm_pend = 0;
    while ((wren_total - wren_base) < stop_bits && cyc < 30000) begin
      sample_valid = 1'b0;
      arm          = 1'b0;
      if (inject) begin
        sample       = 8'h00;          // back-to-back: must be dropped
        sample_valid = 1'b1;
        inject       = 0;
        gap--;
      end else if (gap > 0) begin
        gap--;
      end else if (words < NWORDS) begin
        if (words == 0)           sample = first;
        else if (words == ovr_at) sample = 8'hFF;
        else                      sample = 8'($urandom);
        sample_valid = 1'b1;
        exp_q.push_back(sample);
        inject = (words == ovr_at);
        words++;
        gap = SW - 1 + int'($urandom_range(0, 2));
      end
      if (mid_arm && !arm_done && words == NWORDS / 2) begin
        arm      = 1'b1;
        arm_done = 1;
        arm_pend = 1;
      end
      step();
      cyc++;
      if (arm_pend) begin
        arm_pend = 0;
        chk("arm_in_capture_busy", 32'(busy), 1);
        chk("arm_in_capture_count", 32'(bit_count),
            32'(wren_total - wren_base - int'(wren)));
      end
    end
    sample_valid = 1'b0;
    arm          = 1'b0;
    chk("feed_in_budget", 32'(cyc < 30000), 1);
  endtask

  task automatic finish_capture(input bit exp_ovr);
    int n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    chk("done", 32'(done), 1);
    chk("busy_after_done", 32'(busy), 0);
    chk("bit_count_full", 32'(bit_count), DEPTH);
    chk("wren_cycles", 32'(wren_total - wren_base), DEPTH);
    chk("wren_low_in_done", 32'(wren), 0);
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("word_count", 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (obs_base + i < obs_q.size())
        chk("word", 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
  endtask

  task automatic send_one(input logic [SW-1:0] v);
    sample       = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (SW - 1) step();
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig = 1'b0;
    sample = '0; sample_valid = 1'b0; thr = '0;
    repeat (3) step();
    chk("rst_din", 32'(din), 0);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_bit_count", 32'(bit_count), 0);
    rst = 1'b0;
    step();

    // trig while IDLE does nothing
    trig = 1'b1;
    repeat (6) step();
    trig = 1'b0;
    step();
    chk("idle_trig_armed", 32'(armed), 0);
    chk("idle_trig_busy", 32'(busy), 0);
    chk("idle_trig_nowrites", 32'(wren_total), 0);

    // Capture A: A5 first, arm mid-capture, one overrun pair
    do_arm();
    chk("armed_after_arm", 32'(armed), 1);
    fire_trig();
    feed(DEPTH, 8'hA5, 1'b1, 20);
    if (obs_q.size() > obs_base)
      chk("first_word_A5", 32'(obs_q[obs_base]), 32'h A5);
    finish_capture(1'b1);
    repeat (3) step();
    chk("overrun_sticky_done", 32'(overrun), 1);
    do_arm();
    chk("arm_clears_overrun", 32'(overrun), 0);
    chk("arm_clears_count", 32'(bit_count), 0);
    chk("rearm_armed", 32'(armed), 1);

    // Capture B: reset at bit_count = 1000
    fire_trig();
    feed(1000, 8'h5A, 1'b0, -1);
    step();
    chk("bit_count_1000", 32'(bit_count), 1000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wren", 32'(wren), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_count", 32'(bit_count), 0);
    step();
    rst = 1'b0;
    step();

    // Capture C: full random capture after reset
    do_arm();
    fire_trig();
    feed(DEPTH, 8'($urandom), 1'b0, -1);
    finish_capture(1'b0);
    send_one(8'h33);
    chk("done_ignores_sample_ovr", 32'(overrun), 0);
    chk("done_ignores_sample_wren", 32'(wren_total - wren_base), DEPTH);

    // Threshold crossing
    do_arm();
    thr = 8'h80;
    send_one(8'h10);
    send_one(8'h7F);
    send_one(8'h80);
`ifdef TRIG_THRESHOLD_EN
    chk("thr_trig_busy", 32'(busy), 1);
    send_one(8'h90);
    repeat (4) step();
    chk("thr_word_count", 32'(obs_q.size() - obs_base), 1);
    if (obs_q.size() > obs_base)
      chk("thr_first_word", 32'(obs_q[obs_base]), 32'h90);
`else
    chk("thr_off_armed", 32'(armed), 1);
    chk("thr_off_busy", 32'(busy), 0);
    send_one(8'h90);
    repeat (4) step();
    chk("thr_off_nowrites", 32'(wren_total - wren_base), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
